// File: rtl/array_16_ctrl_if.sv
// rtl/array_16_ctrl_if.sv - request/response/macro bundle for array_16_ctrl
interface array_16_ctrl_if;
  logic         w_valid;
  logic         w_ready;
  logic [8:0]   w_addr;
  logic [7:0]   w_mask;
  logic [103:0] w_data;

  logic         r_valid;
  logic         r_ready;
  logic [8:0]   r_addr;

  logic         resp_valid;
  logic         resp_ready;
  logic [103:0] resp_data;

  logic [8:0]   sram_addr;
  logic         sram_en;
  logic         sram_wmode;
  logic [7:0]   sram_wmask;
  logic [103:0] sram_wdata;
  logic [103:0] sram_rdata;

  modport slave (
    input  w_valid, w_addr, w_mask, w_data,
    output w_ready,
    input  r_valid, r_addr,
    output r_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    output sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output w_valid, w_addr, w_mask, w_data,
    input  w_ready,
    output r_valid, r_addr,
    input  r_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    input  sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/array_16_ctrl.sv
// rtl/array_16_ctrl.sv - write-priority single-port arbiter with read response FIFO
module array_16_ctrl #(
  parameter int RESP_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  array_16_ctrl_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(RESP_DEPTH + 1) + 1;
  localparam int PW = $clog2(RESP_DEPTH);

  logic           alive;
  logic           inflight;
  logic [SW-1:0]  starve_cnt;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [103:0]   mem [RESP_DEPTH];

  logic           pop;
  logic [CW-1:0]  occupancy;
  logic           rd_ok;
  logic           force_rd;
  logic           w_ready_c;
  logic           r_ready_c;
  logic           w_go;
  logic           r_go;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts the in-flight read too, so a push can never find the FIFO full.
  always_comb begin
    pop       = bus.resp_valid && bus.resp_ready;
    occupancy = fifo_count + CW'(inflight) - CW'(pop);
    rd_ok     = occupancy < CW'(RESP_DEPTH);
    force_rd  = (starve_cnt == SW'(STARVE_LIMIT)) && bus.r_valid && rd_ok;
    w_ready_c = alive && !force_rd;
    r_ready_c = alive && rd_ok && (force_rd || !bus.w_valid);
    w_go      = bus.w_valid && w_ready_c;
    r_go      = bus.r_valid && r_ready_c;
  end

  assign bus.w_ready    = w_ready_c;
  assign bus.r_ready    = r_ready_c;
  assign bus.resp_valid = (fifo_count != '0);
  assign bus.resp_data  = mem[head];

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wmask = '0;
    bus.sram_wdata = '0;
    if (w_go) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = bus.w_addr;
      bus.sram_wmask = bus.w_mask;
      bus.sram_wdata = bus.w_data;
    end else if (r_go) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.r_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alive      <= 1'b0;
      inflight   <= 1'b0;
      starve_cnt <= '0;
      fifo_count <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      alive      <= 1'b1;
      inflight   <= r_go;
      fifo_count <= fifo_count + CW'(inflight) - CW'(pop);
      if (inflight) tail <= ptr_inc(tail);
      if (pop)      head <= ptr_inc(head);
      // Credit-only stalls do not count as starvation: writes are not the cause.
      if (r_go)
        starve_cnt <= '0;
      else if (bus.r_valid && !r_ready_c && bus.w_valid &&
               starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (inflight) mem[tail] <= bus.sram_rdata;
  end

endmodule

// File: tb/tb_array_16_ctrl.sv
// tb/tb_array_16_ctrl.sv - model-checked directed bench for array_16_ctrl
module tb_array_16_ctrl;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  array_16_ctrl_if bus();

  array_16_ctrl #(.RESP_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [103:0] merge(input logic [103:0] old_v, input logic [103:0] new_v,
                                         input logic [7:0] mask);
    logic [103:0] r;
    r = old_v;
    for (int l = 0; l < 8; l++)
      if (mask[l]) r[13*l +: 13] = new_v[13*l +: 13];
    return r;
  endfunction

  // Macro stand-in: masked write, one-cycle registered read.
  logic [103:0] sram [512];
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) sram[bus.sram_addr] <= merge(sram[bus.sram_addr], bus.sram_wdata, bus.sram_wmask);
      else bus.sram_rdata <= sram[bus.sram_addr];
    end
  end

  // Reference: memory image, queue of accepted reads, starvation count.
  logic [103:0] model_mem [512];
  logic [103:0] exp_q [$];
  int           age_q [$];
  int           starve_m = 0;
  bit           alive_m = 0;
  int           cyc = 0;

  always @(negedge clock) begin
    int  outstanding;
    bit  exp_rv, pop, rd_ok, frc, ew, er;
    if (!reset_n) begin
      exp_q.delete();
      age_q.delete();
      starve_m = 0;
      alive_m  = 0;
      chk("rst_w_ready", 104'(bus.w_ready), 104'(0));
      chk("rst_r_ready", 104'(bus.r_ready), 104'(0));
      chk("rst_resp_valid", 104'(bus.resp_valid), 104'(0));
      chk("rst_sram_en", 104'(bus.sram_en), 104'(0));
    end else begin
      outstanding = exp_q.size();
      exp_rv = (outstanding > 0) && (age_q[0] <= cyc - 2);
      chk("resp_valid", 104'(bus.resp_valid), 104'(exp_rv));
      pop = exp_rv && bus.resp_ready;
      if (pop) begin
        chk("resp_data", bus.resp_data, exp_q[0]);
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      rd_ok = (outstanding - int'(pop)) < DEPTH;
      frc   = (starve_m == LIMIT) && bus.r_valid && rd_ok;
      ew    = alive_m && !frc;
      er    = alive_m && rd_ok && (frc || !bus.w_valid);
      chk("w_ready", 104'(bus.w_ready), 104'(ew));
      chk("r_ready", 104'(bus.r_ready), 104'(er));
      if (bus.w_valid && ew) begin
        chk("wr_en", {102'(bus.sram_en), bus.sram_wmode}, {102'(1), 1'b1});
        chk("wr_addr", 104'(bus.sram_addr), 104'(bus.w_addr));
        chk("wr_mask", 104'(bus.sram_wmask), 104'(bus.w_mask));
        chk("wr_data", bus.sram_wdata, bus.w_data);
        model_mem[bus.w_addr] = merge(model_mem[bus.w_addr], bus.w_data, bus.w_mask);
      end else if (bus.r_valid && er) begin
        chk("rd_en", {102'(bus.sram_en), bus.sram_wmode}, {102'(1), 1'b0});
        chk("rd_addr", 104'(bus.sram_addr), 104'(bus.r_addr));
        chk("rd_wmask", 104'(bus.sram_wmask), 104'(0));
        exp_q.push_back(model_mem[bus.r_addr]);
        age_q.push_back(cyc);
      end else begin
        chk("idle_en", 104'(bus.sram_en), 104'(0));
      end
      if (bus.r_valid && er) starve_m = 0;
      else if (bus.r_valid && bus.w_valid && starve_m < LIMIT) starve_m++;
      alive_m = 1;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.w_valid = 0;
    bus.r_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [103:0] v;
    int hs, k, grant_at;
    logic [8:0] addrs [4];
    for (int i = 0; i < 512; i++) begin
      sram[i] = '0;
      model_mem[i] = '0;
    end
    bus.sram_rdata = '0;
    bus.w_valid = 0; bus.w_addr = '0; bus.w_mask = '0; bus.w_data = '0;
    bus.r_valid = 0; bus.r_addr = '0; bus.resp_ready = 1;
    repeat (3) step();
    reset_n = 1;
    @(negedge clock);
    chk("pre_alive_w_ready", 104'(bus.w_ready), 104'(0));
    step();

    // Full write then readback of 0x05.
    bus.w_valid = 1; bus.w_addr = 9'h05; bus.w_mask = 8'hFF; bus.w_data = 104'h1ABC;
    @(negedge clock);
    chk("t1_w_ready", 104'(bus.w_ready), 104'(1));
    step();
    bus.w_valid = 0; bus.r_valid = 1; bus.r_addr = 9'h05;
    @(negedge clock);
    chk("t1_r_ready", 104'(bus.r_ready), 104'(1));
    chk("t1_rd_wmask", 104'(bus.sram_wmask), 104'(0));
    step();
    idle();
    @(negedge clock);
    chk("t1_not_yet", 104'(bus.resp_valid), 104'(0));
    step();
    @(negedge clock);
    chk("t1_resp_valid", 104'(bus.resp_valid), 104'(1));
    chk("t1_resp_data", bus.resp_data, 104'h1ABC);
    step();

    // Partial write of lane 0.
    bus.w_valid = 1; bus.w_addr = 9'h10; bus.w_mask = 8'hFF; bus.w_data = ~104'h0;
    step();
    bus.w_mask = 8'h01; bus.w_data = '0;
    step();
    bus.w_valid = 0; bus.r_valid = 1; bus.r_addr = 9'h10;
    step();
    idle();
    step();
    v = ~104'h0;
    v[12:0] = '0;
    @(negedge clock);
    chk("t2_partial", bus.resp_data, v);
    step();

    // Starvation: writes every cycle, one read to 0x20.
    grant_at = 0;
    bus.r_valid = 1; bus.r_addr = 9'h20;
    bus.w_valid = 1; bus.w_mask = 8'hFF;
    for (int i = 1; i <= 10; i++) begin
      bus.w_addr = 9'h40 + 9'(i);
      bus.w_data = 104'(i);
      @(negedge clock);
      if (grant_at == 0 && bus.r_ready) begin
        grant_at = i;
        chk("t3_force_w_ready", 104'(bus.w_ready), 104'(0));
      end
      if (grant_at != 0 && i == grant_at + 1)
        chk("t3_resume_w_ready", 104'(bus.w_ready), 104'(1));
      step();
      if (grant_at != 0) bus.r_valid = 0;
    end
    chk("t3_grant_cycle", 104'(grant_at), 104'(5));
    idle();
    repeat (3) step();

    // Same-address write and read: write first, read returns new value.
    bus.w_valid = 1; bus.w_addr = 9'h30; bus.w_mask = 8'hFF; bus.w_data = 104'hA;
    step();
    bus.w_data = 104'hB; bus.r_valid = 1; bus.r_addr = 9'h30;
    @(negedge clock);
    chk("t4_w_first", {102'(bus.w_ready), bus.r_ready}, {102'(1), 1'b0});
    step();
    bus.w_valid = 0;
    step();
    idle();
    step();
    @(negedge clock);
    chk("t4_resp_b", bus.resp_data, 104'hB);
    repeat (2) step();

    // Response backpressure with 4 reads.
    addrs[0] = 9'h05; addrs[1] = 9'h10; addrs[2] = 9'h30; addrs[3] = 9'h41;
    bus.resp_ready = 0;
    k = 0; hs = 0;
    bus.r_valid = 1; bus.r_addr = addrs[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.r_ready && bus.r_valid) hs++;
      step();
      if (hs > k) begin
        k = hs;
        if (k < 4) bus.r_addr = addrs[k];
        else bus.r_valid = 0;
      end
    end
    chk("t5_hs_blocked", 104'(hs), 104'(2));
    @(negedge clock);
    chk("t5_r_ready_low", 104'(bus.r_ready), 104'(0));
    step();
    bus.resp_ready = 1;
    @(negedge clock);
    chk("t5_first_resp", bus.resp_data, 104'h1ABC);
    for (int i = 0; i < 20 && k < 4; i++) begin
      if (i > 0) @(negedge clock);
      if (bus.r_ready && bus.r_valid) hs++;
      step();
      if (hs > k) begin
        k = hs;
        if (k < 4) bus.r_addr = addrs[k];
        else bus.r_valid = 0;
      end
    end
    chk("t5_hs_total", 104'(hs), 104'(4));
    idle();
    repeat (4) step();

    // Reset one cycle after a read grant discards the read.
    bus.r_valid = 1; bus.r_addr = 9'h05;
    @(negedge clock);
    chk("t6_r_ready", 104'(bus.r_ready), 104'(1));
    step();
    idle();
    reset_n = 0;
    @(negedge clock);
    chk("t6_rst_resp_valid", 104'(bus.resp_valid), 104'(0));
    step();
    step();
    reset_n = 1;
    @(negedge clock);
    chk("t6_pre_alive", 104'(bus.w_ready), 104'(0));
    step();
    @(negedge clock);
    chk("t6_alive", {102'(bus.w_ready), bus.r_ready}, {102'(1), 1'b1});
    chk("t6_no_resp", 104'(bus.resp_valid), 104'(0));
    repeat (4) step();
    @(negedge clock);
    chk("t6_still_no_resp", 104'(bus.resp_valid), 104'(0));
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
